// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch-redirect block.
//   NOP           : canonical bubble instruction (addi x0, x0, 0)
//   fetch_state_t : redirect FSM states
package fetch_pkg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN,
    SHADOW,
    HALT
  } fetch_state_t;

endpackage

// File: rtl/sat_counter16.sv
// 16-bit up-counter that sticks at all-ones.
//   clk_i   : rising-edge clock
//   rst_i   : asynchronous active-high reset, clears the count
//   en_i    : increment request
//   count_o : current count
module sat_counter16 (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  output logic [15:0] count_o
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_o <= 16'h0000;
    end else if (en_i && (count_o != 16'hFFFF)) begin
      count_o <= count_o + 16'h0001;
    end
  end

endmodule

// File: rtl/fetch_redirect.sv
// Instruction-fetch PC and IF/ID register with EX-stage redirect handling.
//   clk, reset   : rising-edge clock, asynchronous active-high reset
//   Stall        : hold PC and IF/ID
//   PcSel, BrPC  : taken branch/jump and its byte target from EX
//   Instr_in     : instruction memory read data for PC
//   PC           : current fetch address
//   IfId_*       : IF/ID pipeline register (PC, instruction, valid)
//   Flush_ID     : combinational squash of the instruction entering ID/EX
//   Misalign     : sticky illegal-target flag; block halts until reset
//   Redirect_Cnt : saturating count of accepted redirects
module fetch_redirect
  import fetch_pkg::*;
#(
  parameter int unsigned PC_W = 9
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Stall,
  input  logic            PcSel,
  input  logic [31:0]     BrPC,
  input  logic [31:0]     Instr_in,
  output logic [PC_W-1:0] PC,
  output logic [PC_W-1:0] IfId_PC,
  output logic [31:0]     IfId_Instr,
  output logic            IfId_Valid,
  output logic            Flush_ID,
  output logic            Misalign,
  output logic [15:0]     Redirect_Cnt
);

  fetch_state_t state_q;

  logic target_legal;
  logic accept;

  // Target must be word aligned and fit inside the PC address space.
  assign target_legal = (BrPC[1:0] == 2'b00) && (BrPC[31:PC_W] == '0);
  assign accept       = (state_q == RUN) && PcSel && target_legal;

  // Any redirect request seen in RUN squashes the instruction behind it,
  // whether it is accepted or sends the block to HALT.
  assign Flush_ID = !reset && (state_q == RUN) && PcSel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      PC         <= '0;
      IfId_PC    <= '0;
      IfId_Instr <= NOP;
      IfId_Valid <= 1'b0;
      Misalign   <= 1'b0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (PcSel) begin
            IfId_Valid <= 1'b0;
            IfId_Instr <= NOP;
            if (target_legal) begin
              PC      <= BrPC[PC_W-1:0];
              state_q <= SHADOW;
            end else begin
              Misalign <= 1'b1;
              state_q  <= HALT;
            end
          end else if (!Stall) begin
            PC         <= PC + PC_W'(3'd4);
            IfId_PC    <= PC;
            IfId_Instr <= Instr_in;
            IfId_Valid <= 1'b1;
          end
        end
        SHADOW: begin
          // EX holds the squashed bubble, so PcSel cannot be genuine here.
          state_q <= RUN;
          if (!Stall) begin
            PC         <= PC + PC_W'(3'd4);
            IfId_PC    <= PC;
            IfId_Instr <= Instr_in;
            IfId_Valid <= 1'b1;
          end
        end
        HALT: begin
          IfId_Valid <= 1'b0;
          IfId_Instr <= NOP;
        end
        default: begin
          state_q <= RUN;
        end
      endcase
    end
  end

  sat_counter16 u_redirect_cnt (
    .clk_i   (clk),
    .rst_i   (reset),
    .en_i    (accept),
    .count_o (Redirect_Cnt)
  );

endmodule

// File: tb/tb_fetch_redirect.sv
module tb_fetch_redirect;

  localparam int unsigned PW = 9;
  localparam logic [31:0] NOP_I = 32'h0000_0013;

  logic          clk;
  logic          reset;
  logic          Stall;
  logic          PcSel;
  logic [31:0]   BrPC;
  logic [31:0]   Instr_in;
  logic [PW-1:0] PC;
  logic [PW-1:0] IfId_PC;
  logic [31:0]   IfId_Instr;
  logic          IfId_Valid;
  logic          Flush_ID;
  logic          Misalign;
  logic [15:0]   Redirect_Cnt;

  int total = 0;
  int bad   = 0;

  fetch_redirect #(
    .PC_W (PW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .Stall        (Stall),
    .PcSel        (PcSel),
    .BrPC         (BrPC),
    .Instr_in     (Instr_in),
    .PC           (PC),
    .IfId_PC      (IfId_PC),
    .IfId_Instr   (IfId_Instr),
    .IfId_Valid   (IfId_Valid),
    .Flush_ID     (Flush_ID),
    .Misalign     (Misalign),
    .Redirect_Cnt (Redirect_Cnt)
  );

  // Instruction memory: distinct, never-NOP word per address.
  function automatic logic [31:0] imem(input logic [PW-1:0] a);
    return 32'h5A00_0000 + 32'(a);
  endfunction

  assign Instr_in = imem(PC);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: integer PC arithmetic and plain mode flags.
  int          m_pc     = 0;
  int          m_ipc    = 0;
  logic [31:0] m_instr  = NOP_I;
  bit          m_valid  = 0;
  bit          m_mis    = 0;
  int          m_cnt    = 0;
  bit          m_shadow = 0;
  bit          m_halt   = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pc <= 0; m_ipc <= 0; m_instr <= NOP_I; m_valid <= 0;
      m_mis <= 0; m_cnt <= 0; m_shadow <= 0; m_halt <= 0;
    end else if (m_halt) begin
      m_valid <= 0;
      m_instr <= NOP_I;
    end else if (!m_shadow && PcSel) begin
      m_valid <= 0;
      m_instr <= NOP_I;
      if ((BrPC % 4 == 0) && (BrPC < (32'd1 << PW))) begin
        m_pc     <= int'(BrPC);
        m_cnt    <= (m_cnt < 65535) ? m_cnt + 1 : 65535;
        m_shadow <= 1;
      end else begin
        m_mis  <= 1;
        m_halt <= 1;
      end
    end else begin
      m_shadow <= 0;
      if (!Stall) begin
        m_ipc   <= m_pc;
        m_instr <= imem(PW'(m_pc));
        m_valid <= 1;
        m_pc    <= (m_pc + 4) % (1 << PW);
      end
    end
  end

  always @(negedge clk) begin
    chk("pc", 32'(PC), 32'(m_pc));
    chk("ifid_pc", 32'(IfId_PC), 32'(m_ipc));
    chk("ifid_instr", IfId_Instr, m_instr);
    chk("ifid_valid", 32'(IfId_Valid), 32'(m_valid));
    chk("misalign", 32'(Misalign), 32'(m_mis));
    chk("redirect_cnt", 32'(Redirect_Cnt), 32'(m_cnt));
    chk("flush_id", 32'(Flush_ID), 32'(!reset && !m_halt && !m_shadow && PcSel));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; Stall = 1'b0; PcSel = 1'b0; BrPC = 32'h0;
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", 32'(PC), 32'h0);
    chk("rst_instr", IfId_Instr, NOP_I);
    chk("rst_valid", 32'(IfId_Valid), 32'h0);
    chk("rst_cnt", 32'(Redirect_Cnt), 32'h0);
    reset = 1'b0;

    // Sequential fetch
    chk("seq_pc0", 32'(PC), 32'h0);
    step(); chk("seq_pc4", 32'(PC), 32'h4); chk("seq_ipc0", 32'(IfId_PC), 32'h0);
    chk("seq_valid", 32'(IfId_Valid), 32'h1);
    step(); chk("seq_pc8", 32'(PC), 32'h8); chk("seq_ipc4", 32'(IfId_PC), 32'h4);
    step(); chk("seq_pc12", 32'(PC), 32'hC);
    step(); chk("seq_pc16", 32'(PC), 32'h10);

    // Legal redirect to 0x40
    PcSel = 1'b1; BrPC = 32'h40;
    #1 chk("redir_flush", 32'(Flush_ID), 32'h1);
    step(); PcSel = 1'b0;
    chk("redir_pc", 32'(PC), 32'h40);
    chk("redir_valid0", 32'(IfId_Valid), 32'h0);
    chk("redir_nop", IfId_Instr, NOP_I);
    chk("redir_cnt", 32'(Redirect_Cnt), 32'h1);
    step();
    chk("redir_ipc", 32'(IfId_PC), 32'h40);
    chk("redir_valid1", 32'(IfId_Valid), 32'h1);
    chk("redir_instr", IfId_Instr, 32'h5A00_0040);

    // PcSel beats Stall; PcSel in SHADOW ignored
    PcSel = 1'b1; Stall = 1'b1; BrPC = 32'h80;
    step(); chk("prio_pc", 32'(PC), 32'h80);
    Stall = 1'b0; BrPC = 32'h100;
    #1 chk("shadow_noflush", 32'(Flush_ID), 32'h0);
    step(); PcSel = 1'b0;
    chk("shadow_pc", 32'(PC), 32'h84);
    chk("shadow_cnt", 32'(Redirect_Cnt), 32'h2);

    // Stall at PC=0x20
    PcSel = 1'b1; BrPC = 32'h1C;
    step(); PcSel = 1'b0;
    step(); chk("stall_start", 32'(PC), 32'h20);
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", 32'(PC), 32'h20);
      chk("stall_ipc", 32'(IfId_PC), 32'h1C);
    end
    Stall = 1'b0;
    step(); chk("unstall_pc", 32'(PC), 32'h24); chk("unstall_ipc", 32'(IfId_PC), 32'h20);

    // PC wrap
    PcSel = 1'b1; BrPC = 32'h1F8;
    step(); PcSel = 1'b0;
    step(); chk("wrap_1fc", 32'(PC), 32'h1FC);
    step(); chk("wrap_0", 32'(PC), 32'h0); chk("wrap_ipc", 32'(IfId_PC), 32'h1FC);

    // Reset mid-SHADOW acts without a clock edge
    PcSel = 1'b1; BrPC = 32'h40;
    step(); PcSel = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("arst_pc", 32'(PC), 32'h0);
    chk("arst_valid", 32'(IfId_Valid), 32'h0);
    chk("arst_instr", IfId_Instr, NOP_I);
    chk("arst_cnt", 32'(Redirect_Cnt), 32'h0);
    step(); reset = 1'b0;
    step(); step(); chk("pre_mis_pc", 32'(PC), 32'h8);

    // Misaligned target halts
    PcSel = 1'b1; BrPC = 32'h42;
    #1 chk("mis_flush", 32'(Flush_ID), 32'h1);
    step(); BrPC = 32'h40;
    chk("mis_flag", 32'(Misalign), 32'h1);
    chk("mis_pc", 32'(PC), 32'h8);
    chk("halt_noflush", 32'(Flush_ID), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("halt_pc", 32'(PC), 32'h8);
      chk("halt_valid", 32'(IfId_Valid), 32'h0);
    end
    PcSel = 1'b0;
    reset = 1'b1;
    #1 chk("mis_clear", 32'(Misalign), 32'h0);
    step(); reset = 1'b0;

    // Out-of-range target halts
    PcSel = 1'b1; BrPC = 32'h200;
    step(); PcSel = 1'b0;
    chk("oor_flag", 32'(Misalign), 32'h1);
    chk("oor_pc", 32'(PC), 32'h0);
    step(); chk("oor_valid", 32'(IfId_Valid), 32'h0);
    reset = 1'b1;
    #1 chk("oor_clear", 32'(Misalign), 32'h0);
    step(); reset = 1'b0;
    step(); chk("restart_pc", 32'(PC), 32'h4);

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_redirect.md
FETCH_REDIRECT -- requirements
Module: fetch_redirect

Interface
REQ-001 SHALL have parameter PC_W, default 9, meaning the byte-address width of the program counter.
REQ-002 SHALL have one clock and an asynchronous, active-high reset.
REQ-003 SHALL have port clk, input, 1, the single rising-edge clock.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port Stall, input, 1, hazard request to hold PC and IF/ID.
REQ-006 SHALL have port PcSel, input, 1, branch/jump taken, from the EX-stage branch unit.
REQ-007 SHALL have port BrPC, input, 32, redirect target byte address.
REQ-008 SHALL have port Instr_in, input, 32, instruction-memory read data for PC (combinational read).
REQ-009 SHALL have port PC, output, PC_W, current fetch address to instruction memory.
REQ-010 SHALL have ports IfId_PC (output, PC_W), IfId_Instr (output, 32) and IfId_Valid (output, 1), the IF/ID pipeline register.
REQ-011 SHALL have port Flush_ID, output, 1, combinational squash of the instruction entering ID/EX this cycle.
REQ-012 SHALL have port Misalign, output, 1, sticky flag for an illegal redirect target.
REQ-013 SHALL have port Redirect_Cnt, output, 16, count of accepted redirects.

Function
REQ-014 SHALL implement an FSM with states RUN, SHADOW and HALT.
REQ-015 In RUN, a legal redirect SHALL be accepted when PcSel=1 and BrPC[1:0]=0 and BrPC[31:PC_W]=0.
- Accepting a legal redirect: PC <= BrPC[PC_W-1:0]; IfId_Valid <= 0; IfId_Instr <= NOP; Flush_ID=1 in the same cycle; Redirect_Cnt increments; next state SHADOW.
REQ-016 In RUN with PcSel=1 and an illegal target, the block SHALL go to HALT.
- Entering HALT: Misalign <= 1; IfId_Valid <= 0; Flush_ID=1; PC holds its value.
REQ-017 In RUN with PcSel=0 and Stall=0, the block SHALL do the following:
- PC <= PC+4, wrapping modulo 2^PC_W.
- IfId_PC <= PC; IfId_Instr <= Instr_in; IfId_Valid <= 1.
REQ-018 In RUN with PcSel=0 and Stall=1, PC and all IfId_* outputs SHALL hold.
REQ-019 PcSel=1 SHALL take priority over Stall=1 when both occur in the same cycle.
REQ-020 SHADOW SHALL last exactly one cycle, then return to RUN.
- PcSel is ignored in SHADOW because the EX stage holds a squashed bubble.
- Fetch advances as in REQ-017/REQ-018, so the target instruction reaches IF/ID with IfId_Valid=1 one cycle after acceptance.
REQ-021 HALT SHALL be terminal until reset.
- PC holds; IfId_Valid=0; IfId_Instr=NOP; Flush_ID=0; Stall and PcSel are ignored.
REQ-022 Flush_ID SHALL be 0 in every case not named in REQ-015/REQ-016.
REQ-023 Redirect_Cnt SHALL saturate at 16'hFFFF.
REQ-024 When IfId_Valid=0, IfId_Instr SHALL equal NOP (32'h00000013).
REQ-025 PC SHALL be bits [PC_W-1:0] of the 32-bit arithmetic result.

Reset
REQ-026 On reset assertion, all registered outputs SHALL take their reset values asynchronously:
- PC=0, IfId_PC=0, IfId_Instr=NOP, IfId_Valid=0, Misalign=0, Redirect_Cnt=0, state RUN.
REQ-027 Reset SHALL override any operation in progress, including a redirect in the same cycle, SHADOW and HALT.
REQ-028 The first fetch after reset deassertion SHALL be from address 0.

Structure
REQ-029 Package fetch_pkg SHALL hold the NOP constant and the fetch_state_t enum (RUN, SHADOW, HALT).
REQ-030 A sub-module sat_counter16 (enable, saturating, asynchronous reset) SHALL implement Redirect_Cnt; everything else stays in fetch_redirect.

Verification
REQ-031 The bench SHALL cover these directed scenarios:
- Reset released, Stall=0, PcSel=0 for 4 cycles -> PC 0,4,8,12; IfId_PC trails PC by 1 cycle; IfId_Valid=1 from cycle 2.
- At PC=0x10, PcSel=1, BrPC=0x40 -> Flush_ID=1 that cycle; next cycle PC=0x40 and IfId_Valid=0; the following cycle IfId_PC=0x40 and IfId_Valid=1; Redirect_Cnt=1.
- PcSel=1 and Stall=1 together, BrPC=0x80 -> redirect taken (PC=0x80); PcSel=1 in the SHADOW cycle is ignored.
- BrPC=0x42, or BrPC=0x200 with PC_W=9 -> Misalign=1; PC frozen; IfId_Valid stays 0 until reset; reset clears Misalign.
- PC=0x1FC with PC_W=9, no stall -> next PC=0x000.
- Stall=1 for 3 cycles at PC=0x20 -> PC and IfId_* unchanged; advance resumes on release. Reset asserted mid-SHADOW -> all outputs at reset values immediately, without waiting for a clock edge.
